prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream boot loader: the writer side of the instruction-memory port that the single-cycle core reads.
- Receives a framed program image over a byte valid/ready interface and assembles big-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses (memory is word-addressed; PC steps by 1).
- Holds the core in reset until the image is fully loaded and the checksum verifies.

Parameters:
- BASE_ADDR, 32'd0, word address of the first written word.
- MAX_WORDS, 16'd1024, largest accepted word count; any larger length field is an error.

Ports:
- clk  in  1  system clock, rising-edge.
- res  in  1  asynchronous, active-high reset.
- load_start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid & byte_ready.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  word address.
- mem_wdata  out  32  word data.
- cpu_res  out  1  reset to the core; high until a load completes successfully.
- busy  out  1  load in progress.
- done  out  1  last load succeeded; sticky until the next load_start.
- err  out  1  last load failed; sticky until the next load_start.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_res=1, busy=0, done=0, err=0, internal counters and checksum=0.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes MSB first, then CSUM (XOR of all data bytes only).
- IDLE/DONE/ERR + load_start -> LEN_HI. On entry: busy=1, done=0, err=0, cpu_res=1, checksum=0, word index=0, byte count=0.
- LEN_HI -> LEN_LO -> DATA on accepted bytes. After LEN_LO:
  - N > MAX_WORDS -> ERR.
  - N = 0 -> CSUM.
- DATA: each accepted byte shifts into the word register (wdata = {wdata[23:0], byte}) and XORs into the checksum. The 4th byte of a word -> WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=BASE_ADDR+index, mem_wdata=assembled word; byte_ready=0.
  - Index increments. If index == N-1 -> CSUM, else -> DATA.
  - Latency: mem_we is high in the cycle immediately after the 4th byte's handshake.
- byte_ready=1 in LEN_HI, LEN_LO, DATA, CSUM; 0 in IDLE, WRITE, DONE, ERR.
- CSUM: on an accepted byte:
  - match -> DONE (busy=0, done=1, cpu_res=0 from the next cycle).
  - mismatch -> ERR (busy=0, err=1, cpu_res stays 1).
- mem_we is 0 in every state except WRITE. mem_addr and mem_wdata hold their last values otherwise.
- byte_valid low simply stalls; partial words and counters are retained indefinitely (no timeout).
- load_start while busy is ignored.
- A new load after DONE reasserts cpu_res=1 in the cycle after load_start.
- Address arithmetic is modulo 2^32 (BASE_ADDR+index wraps).
- res asserted mid-load: immediate return to the reset values. Words already written stay in memory; no further writes occur.

Test Plan:
- Reset, then idle 5 cycles -> cpu_res=1, byte_ready=0, mem_we=0, busy=0, done=0, err=0.
- load_start; bytes 00 02 12 34 56 78 9A BC DE F0 then CSUM 00 (XOR of the 8 data bytes) -> writes addr 0 = 0x12345678, addr 1 = 0x9ABCDEF0, each one cycle after the 4th byte; done=1; cpu_res=0.
- Same image with CSUM 0x01 -> both writes occur, err=1, done=0, cpu_res stays 1; then a load_start plus a correct frame -> done=1.
- Length 00 00, CSUM 00 -> no mem_we, done=1. Length 0x0401 with MAX_WORDS=1024 -> err=1 immediately, no writes.
- Two-word image with byte_valid toggling randomly (gaps of 0-3 cycles) and BASE_ADDR=0x100 -> identical words at 0x100 and 0x101; byte_ready=0 during each WRITE cycle.
- Assert res after 6 data bytes of a 2-word load -> only addr 0 written, all outputs at reset values; a full reload afterwards succeeds.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream boot loader: assembles big-endian words from a framed image, writes them to
// instruction memory and holds the core in reset until the checksum verifies.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [15:0] MAX_WORDS = 16'd1024
) (
    input  logic        clk,
    input  logic        res,
    input  logic        load_start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_res,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CSUM   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]  state;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [7:0]  csum;
    logic        fire;

    assign fire = byte_valid & byte_ready;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
            cpu_res    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len        <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            csum       <= 8'd0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_start) begin
                        state      <= S_LEN_HI;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        cpu_res    <= 1'b1;
                        csum       <= 8'd0;
                        word_idx   <= 16'd0;
                        byte_cnt   <= 2'd0;
                    end
                end
                S_LEN_HI: begin
                    if (fire) begin
                        len[15:8] <= byte_in;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (fire) begin
                        len[7:0] <= byte_in;
                        if ({len[15:8], byte_in} > MAX_WORDS) begin
                            state      <= S_ERR;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            err        <= 1'b1;
                        end else if ({len[15:8], byte_in} == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        shift    <= {shift[15:0], byte_in};
                        csum     <= csum ^ byte_in;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Fourth byte: present the word on the memory port next cycle.
                        if (byte_cnt == 2'd3) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                            mem_addr   <= BASE_ADDR + {16'd0, word_idx};
                            mem_wdata  <= {shift, byte_in};
                        end
                    end
                end
                S_WRITE: begin
                    word_idx   <= word_idx + 16'd1;
                    byte_ready <= 1'b1;
                    state      <= (word_idx == len - 16'd1) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (fire) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_in == csum) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_res <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (base 0 and base 0x100) share one byte stream.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        res;
    logic        load_start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        byte_ready_a, mem_we_a, cpu_res_a, busy_a, done_a, err_a;
    logic [31:0] mem_addr_a, mem_wdata_a;
    logic        byte_ready_b, mem_we_b, cpu_res_b, busy_b, done_b, err_b;
    logic [31:0] mem_addr_b, mem_wdata_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
    logic        prev_fire;
    logic [7:0]  frame [11];

    always #5 clk = ~clk;

    prog_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(16'd1024)) u_dut_a (
        .clk(clk), .res(res), .load_start(load_start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .cpu_res(cpu_res_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    prog_loader #(.BASE_ADDR(32'h100), .MAX_WORDS(16'd1024)) u_dut_b (
        .clk(clk), .res(res), .load_start(load_start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .cpu_res(cpu_res_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are stable at the falling edge; mem_we must follow a 4th-byte handshake directly.
    always @(negedge clk) begin
        if (mem_we_a) begin
            check("we_latency", {31'd0, prev_fire}, 32'd1);
            check("ready_low_in_write", {31'd0, byte_ready_a}, 32'd0);
            wa_addr.push_back(mem_addr_a);
            wa_data.push_back(mem_wdata_a);
        end
        if (mem_we_b) begin
            check("ready_low_in_write_b", {31'd0, byte_ready_b}, 32'd0);
            wb_addr.push_back(mem_addr_b);
            wb_data.push_back(mem_wdata_b);
        end
        prev_fire <= byte_valid & byte_ready_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_in    = b;
        waited     = 0;
        while (!byte_ready_a && waited < 50) begin
            tick();
            waited++;
        end
        if (!byte_ready_a) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int max_gap);
        for (int i = 0; i < n; i++) send_byte(frame[i], int'($urandom_range(0, max_gap)));
    endtask

    task automatic set_good(input logic [7:0] c);
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, c};
    endtask

    task automatic check_two_words_a();
        check("wr_count", wa_addr.size(), 32'd2);
        if (wa_addr.size() == 2) begin
            check("addr0", wa_addr[0], 32'h0);
            check("data0", wa_data[0], 32'h12345678);
            check("addr1", wa_addr[1], 32'h1);
            check("data1", wa_data[1], 32'h9ABCDEF0);
        end
    endtask

    initial begin
        res = 1'b1; load_start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        repeat (3) tick();
        res = 1'b0;
        repeat (5) tick();
        check("rst_cpu_res", {31'd0, cpu_res_a}, 32'd1);
        check("rst_ready", {31'd0, byte_ready_a}, 32'd0);
        check("rst_we", {31'd0, mem_we_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_addr_b", mem_addr_b, 32'h100);
        check("rst_wdata", mem_wdata_a, 32'd0);

        // Good two-word image.
        clear_log();
        start_load();
        check("busy_after_start", {31'd0, busy_a}, 32'd1);
        check("ready_after_start", {31'd0, byte_ready_a}, 32'd1);
        set_good(8'h00);
        send_frame(11, 0);
        check("good_done", {31'd0, done_a}, 32'd1);
        check("good_cpu_res", {31'd0, cpu_res_a}, 32'd0);
        check("good_busy", {31'd0, busy_a}, 32'd0);
        check("good_ready", {31'd0, byte_ready_a}, 32'd0);
        check_two_words_a();

        // Bad checksum, then a clean reload.
        clear_log();
        start_load();
        check("reload_cpu_res", {31'd0, cpu_res_a}, 32'd1);
        check("reload_done_clr", {31'd0, done_a}, 32'd0);
        set_good(8'h01);
        send_frame(11, 0);
        check("bad_err", {31'd0, err_a}, 32'd1);
        check("bad_done", {31'd0, done_a}, 32'd0);
        check("bad_cpu_res", {31'd0, cpu_res_a}, 32'd1);
        check_two_words_a();
        clear_log();
        start_load();
        check("err_clr", {31'd0, err_a}, 32'd0);
        set_good(8'h00);
        send_frame(11, 0);
        check("retry_done", {31'd0, done_a}, 32'd1);
        check("retry_cpu_res", {31'd0, cpu_res_a}, 32'd0);

        // Zero-length image.
        clear_log();
        start_load();
        frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(3, 0);
        repeat (2) tick();
        check("zero_done", {31'd0, done_a}, 32'd1);
        check("zero_writes", wa_addr.size(), 32'd0);

        // Length one past MAX_WORDS fails right after the length bytes.
        clear_log();
        start_load();
        frame = '{8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(2, 0);
        check("long_err", {31'd0, err_a}, 32'd1);
        check("long_busy", {31'd0, busy_a}, 32'd0);
        check("long_ready", {31'd0, byte_ready_a}, 32'd0);
        repeat (3) tick();
        check("long_writes", wa_addr.size(), 32'd0);

        // Gappy stream; checked on the base-0x100 instance.
        clear_log();
        start_load();
        set_good(8'h00);
        send_frame(11, 3);
        check("gap_done_b", {31'd0, done_b}, 32'd1);
        check("gap_count_b", wb_addr.size(), 32'd2);
        if (wb_addr.size() == 2) begin
            check("gap_addr0_b", wb_addr[0], 32'h100);
            check("gap_data0_b", wb_data[0], 32'h12345678);
            check("gap_addr1_b", wb_addr[1], 32'h101);
            check("gap_data1_b", wb_data[1], 32'h9ABCDEF0);
        end

        // Reset after 6 data bytes: only the first word lands.
        clear_log();
        start_load();
        set_good(8'h00);
        send_frame(8, 0);
        tick();
        res = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, byte_ready_a}, 32'd0);
        check("mid_rst_we", {31'd0, mem_we_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check("mid_rst_done", {31'd0, done_a}, 32'd0);
        check("mid_rst_err", {31'd0, err_a}, 32'd0);
        check("mid_rst_cpu_res", {31'd0, cpu_res_a}, 32'd1);
        check("mid_rst_addr", mem_addr_a, 32'd0);
        check("mid_rst_wdata", mem_wdata_a, 32'd0);
        repeat (2) tick();
        res = 1'b0;
        repeat (3) tick();
        check("mid_rst_writes", wa_addr.size(), 32'd1);
        if (wa_addr.size() == 1) check("mid_rst_data0", wa_data[0], 32'h12345678);
        clear_log();
        start_load();
        send_frame(11, 0);
        check("after_rst_done", {31'd0, done_a}, 32'd1);
        check_two_words_a();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
